cnn_layer_accel_octo_datain_feeder: RTL and testbench
=====================================================

Name: cnn_layer_accel_octo_datain_feeder

Overview:
- Transmit end of the octo BRAM controller's input interface: streams one map's sequencer words, then its padded pixel rows, over datain_valid / seq_datain_tag / pixel_datain_tag.
- Honours the controller's seq_datain_rdy / pixel_datain_rdy.
- Pulls words from an upstream first-word-fall-through FIFO.
- Issues new_map to start the controller and pulses done after the last pixel is accepted.

Parameters:
- C_DATA_WIDTH, 16: datain word width.
- C_BRAM_DEPTH, 1024: matches controller; row/col width CW = clog2(C_BRAM_DEPTH)-1.
- C_SEQ_CNT_WIDTH, 12: sequencer word counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin one map; sampled in ST_IDLE only
- cfg_num_seq_words  in  C_SEQ_CNT_WIDTH  sequencer words to send (N>=1)
- cfg_last_col  in  CW  last column index (columns = cfg_last_col+1)
- cfg_last_row  in  CW  last row index (rows = cfg_last_row+1)
- src_valid  in  1  FIFO not empty (FWFT)
- src_data  in  C_DATA_WIDTH  FIFO head word
- src_rden  out  1  pop FIFO head
- new_map  out  1  one-cycle start pulse to controller
- datain_valid  out  1  datain word valid
- datain  out  C_DATA_WIDTH  word
- seq_datain_tag  out  1  word is sequencer data
- pixel_datain_tag  out  1  word is pixel data
- seq_datain_rdy  in  1  controller accepts sequencer word
- pixel_datain_rdy  in  1  controller accepts pixel word
- busy  out  1  not in ST_IDLE
- done  out  1  one-cycle pulse, map complete

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. Reset drives all outputs 0 and the state to ST_IDLE. Reset mid-map abandons the map; no partial-state recovery.
- Output register: one word holding stage (valid, data, tags).
- Transfer: a transfer occurs in a cycle with datain_valid && matching tag && matching rdy. The controller's rdy is registered one cycle after valid, so valid/data/tags must hold unchanged until the transfer.
- Load: the stage loads from the FIFO (src_rden=1) when src_valid && (stage empty || transfer this cycle) && words remain in the current phase.
- Phase boundary: never prefetch across a phase boundary.
- Throughput: 1 word/clk when rdy is held high.
- ST_IDLE: on start, latch cfg_*, pulse new_map, clear counters, go to ST_SEQ. Start while busy is ignored.
- ST_SEQ:
  - seq_datain_tag=1 whenever the stage is valid.
  - seq_sent increments per transfer.
  - When seq_sent reaches cfg_num_seq_words and the stage is empty, go to ST_PIX.
  - Tags change only when the stage is empty.
- ST_PIX:
  - pixel_datain_tag=1 whenever the stage is valid.
  - col counts transfers 0..cfg_last_col, then wraps to 0 and row increments.
  - On the transfer where col==cfg_last_col && row==cfg_last_row, go to ST_DONE.
  - The controller may hold rdy low for arbitrarily long stretches (row stalls); the feeder just holds the word.
- ST_DONE: pulse done for 1 cycle, then return to ST_IDLE.
- FIFO empty: datain_valid drops after the current word transfers; resume when src_valid returns. No word loss or duplication.
- Counters: all counters are unsigned, with no wrap beyond configured limits.
- Protocol assertions (simulation):
  - Both tags high simultaneously is illegal.
  - datain/tag change while valid && !rdy is illegal.

Decomposition:
- Shared package cnn_layer_accel_defs.vh gains:
  - feeder state one-hot localparams ST_FD_IDLE/SEQ/PIX/DONE;
  - CW derivation from clog2(C_BRAM_DEPTH).
- One natural sub-module: cnn_layer_accel_hold_reg, a single-entry valid/data/tag holding stage with load/transfer control.

Test Plan:
- N=4 seq words, last_col=3, last_row=2, FIFO prefilled, rdy=1 always -> new_map 1 cycle after start; 4 seq transfers then 12 pixel transfers on consecutive cycles; done pulses once; data order equals FIFO order.
- Controller stalls pixel_datain_rdy low for 20 cycles after each 4-word row -> datain/tag stable throughout each stall; 12 pixels total; no duplicates.
- FIFO starves for 5 cycles mid-seq phase -> datain_valid low while empty; seq count still exactly N; tag switch occurs only after the 4th seq transfer.
- start pulsed again during ST_PIX -> ignored; a single done; busy stays 1 until done.
- rst asserted mid-ST_PIX -> next cycle all outputs 0 and state ST_IDLE; a subsequent start runs a full map correctly.
- last_col=0, last_row=0, N=1 -> exactly 1 seq word and 1 pixel word; done follows the pixel transfer.

Source files
------------

// File: rtl/cnn_layer_accel_octo_datain_feeder_pkg.sv
// Shared definitions for the octo datain feeder: state encodings, tag payload, CW derivation.
package cnn_layer_accel_octo_datain_feeder_pkg;

    localparam int unsigned FD_STATE_W = 4;

    localparam logic [FD_STATE_W-1:0] ST_FD_IDLE = 4'b0001;
    localparam logic [FD_STATE_W-1:0] ST_FD_SEQ  = 4'b0010;
    localparam logic [FD_STATE_W-1:0] ST_FD_PIX  = 4'b0100;
    localparam logic [FD_STATE_W-1:0] ST_FD_DONE = 4'b1000;

    typedef struct packed {
        logic seq;
        logic pix;
    } fd_tag_t;

    // Row/column index width used by the octo BRAM controller.
    function automatic int unsigned fd_cw(input int unsigned depth);
        return $clog2(depth) - 1;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_hold_reg.sv
// Single-entry holding stage: word, tags and valid stay put until transferred.
module cnn_layer_accel_hold_reg
    import cnn_layer_accel_octo_datain_feeder_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         xfer,
    input  logic [W-1:0] load_data,
    input  fd_tag_t      load_tag,
    output logic         valid,
    output logic [W-1:0] data,
    output fd_tag_t      tag
);

    // Load wins over transfer so a same-cycle transfer+refill keeps the stage full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
        end else if (xfer) begin
            valid <= 1'b0;
            tag   <= '0;
        end
    end

endmodule

// File: rtl/cnn_layer_accel_octo_datain_feeder.sv
// Streams one map's sequencer words then padded pixel rows from a FWFT FIFO to the octo BRAM controller.
module cnn_layer_accel_octo_datain_feeder
    import cnn_layer_accel_octo_datain_feeder_pkg::*;
#(
    parameter  int unsigned C_DATA_WIDTH    = 16,
    parameter  int unsigned C_BRAM_DEPTH    = 1024,
    parameter  int unsigned C_SEQ_CNT_WIDTH = 12,
    localparam int unsigned CW              = fd_cw(C_BRAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [C_SEQ_CNT_WIDTH-1:0] cfg_num_seq_words,
    input  logic [CW-1:0]              cfg_last_col,
    input  logic [CW-1:0]              cfg_last_row,
    input  logic                       src_valid,
    input  logic [C_DATA_WIDTH-1:0]    src_data,
    output logic                       src_rden,
    output logic                       new_map,
    output logic                       datain_valid,
    output logic [C_DATA_WIDTH-1:0]    datain,
    output logic                       seq_datain_tag,
    output logic                       pixel_datain_tag,
    input  logic                       seq_datain_rdy,
    input  logic                       pixel_datain_rdy,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SW = C_SEQ_CNT_WIDTH;

    logic [FD_STATE_W-1:0] state;
    logic [FD_STATE_W-1:0] state_next;
    logic [SW-1:0]         num_seq_q;
    logic [SW-1:0]         seq_sent;
    logic [CW-1:0]         last_col_q;
    logic [CW-1:0]         last_row_q;
    logic [CW-1:0]         col;
    logic [CW-1:0]         row;

    logic    stage_valid;
    fd_tag_t stage_tag;
    fd_tag_t load_tag;
    logic    load;
    logic    load_en;
    logic    xfer;
    logic    seq_more;
    logic    seq_final;
    logic    pix_last;
    logic    start_map;

    assign xfer      = stage_valid && ((stage_tag.seq && seq_datain_rdy) ||
                                       (stage_tag.pix && pixel_datain_rdy));
    // Words still to fetch this phase, counting a transfer completing this cycle.
    assign seq_more  = ({1'b0, seq_sent} + (SW+1)'(xfer)) < {1'b0, num_seq_q};
    assign seq_final = ({1'b0, seq_sent} + (SW+1)'(1)) == {1'b0, num_seq_q};
    assign pix_last  = (col == last_col_q) && (row == last_row_q);
    assign start_map = (state == ST_FD_IDLE) && start;
    assign load_en   = load && !rst;
    assign src_rden  = load_en;

    assign datain_valid     = stage_valid;
    assign seq_datain_tag   = stage_tag.seq;
    assign pixel_datain_tag = stage_tag.pix;

    cnn_layer_accel_hold_reg #(
        .W (C_DATA_WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load_en),
        .xfer      (xfer),
        .load_data (src_data),
        .load_tag  (load_tag),
        .valid     (stage_valid),
        .data      (datain),
        .tag       (stage_tag)
    );

    // Next state and stage load control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_tag   = '0;
        case (state)
            ST_FD_IDLE: begin
                if (start) state_next = ST_FD_SEQ;
            end
            ST_FD_SEQ: begin
                load_tag.seq = 1'b1;
                load         = src_valid && (!stage_valid || xfer) && seq_more;
                if ((xfer && seq_final) || (!stage_valid && (seq_sent == num_seq_q)))
                    state_next = ST_FD_PIX;
            end
            ST_FD_PIX: begin
                load_tag.pix = 1'b1;
                load         = src_valid && (!stage_valid || (xfer && !pix_last));
                if (xfer && pix_last) state_next = ST_FD_DONE;
            end
            ST_FD_DONE: begin
                state_next = ST_FD_IDLE;
            end
            default: begin
                state_next = ST_FD_IDLE;
            end
        endcase
    end

    // State, registered status outputs, configuration and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FD_IDLE;
            new_map    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            num_seq_q  <= '0;
            last_col_q <= '0;
            last_row_q <= '0;
            seq_sent   <= '0;
            col        <= '0;
            row        <= '0;
        end else begin
            state   <= state_next;
            new_map <= start_map;
            done    <= (state_next == ST_FD_DONE);
            busy    <= (state_next != ST_FD_IDLE);
            if (start_map) begin
                num_seq_q  <= cfg_num_seq_words;
                last_col_q <= cfg_last_col;
                last_row_q <= cfg_last_row;
                seq_sent   <= '0;
                col        <= '0;
                row        <= '0;
            end
            if ((state == ST_FD_SEQ) && xfer) seq_sent <= seq_sent + SW'(1);
            if ((state == ST_FD_PIX) && xfer) begin
                if (pix_last) begin
                    col <= '0;
                    row <= '0;
                end else if (col == last_col_q) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic    stall_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    fd_tag_t tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            stall_q <= stage_valid && !xfer;
            data_q  <= datain;
            tag_q   <= stage_tag;
        end
    end

    // Protocol checks: exclusive tags, and a stalled word must hold unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(stage_tag.seq && stage_tag.pix));
            if (stall_q) assert (stage_valid && (datain == data_q) && (stage_tag == tag_q));
        end
    end
`endif

endmodule

// File: tb/tb_cnn_layer_accel_octo_datain_feeder.sv
// Scoreboard bench for the octo datain feeder: FWFT FIFO model, controller rdy driver, per-scenario checks.
module tb_cnn_layer_accel_octo_datain_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 9;
    localparam int unsigned SW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] cfg_num_seq_words;
    logic [CW-1:0] cfg_last_col;
    logic [CW-1:0] cfg_last_row;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_rden;
    logic          new_map;
    logic          datain_valid;
    logic [DW-1:0] datain;
    logic          seq_datain_tag;
    logic          pixel_datain_tag;
    logic          seq_datain_rdy;
    logic          pixel_datain_rdy;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] fifo[$];
    logic [DW+1:0] sb[$];
    bit            pop_pending = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW+1:0] prev_obs = '0;

    int cyc = 0;
    int seq_xfers, pix_xfers, first_seq_cyc, last_seq_cyc, first_pix_cyc, last_pix_cyc;
    int done_cnt, done_cyc, new_map_cnt, new_map_cyc, start_cyc, stall_cycles;

    always #5 clk = ~clk;

    cnn_layer_accel_octo_datain_feeder dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_num_seq_words (cfg_num_seq_words),
        .cfg_last_col      (cfg_last_col),
        .cfg_last_row      (cfg_last_row),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_rden          (src_rden),
        .new_map           (new_map),
        .datain_valid      (datain_valid),
        .datain            (datain),
        .seq_datain_tag    (seq_datain_tag),
        .pixel_datain_tag  (pixel_datain_tag),
        .seq_datain_rdy    (seq_datain_rdy),
        .pixel_datain_rdy  (pixel_datain_rdy),
        .busy              (busy),
        .done              (done)
    );

    // FWFT FIFO model plus transfer monitor; samples 2 time units after each negedge.
    always @(negedge clk) begin
        logic [DW-1:0] junk;
        logic [DW+1:0] exp_w;
        logic [DW+1:0] obs;
        bit            x;
        if (pop_pending && fifo.size() > 0) junk = fifo.pop_front();
        src_valid = (fifo.size() > 0);
        src_data  = src_valid ? fifo[0] : '0;
        #2;
        cyc++;
        pop_pending = src_rden && src_valid;
        x   = datain_valid && ((seq_datain_tag && seq_datain_rdy) || (pixel_datain_tag && pixel_datain_rdy));
        obs = {seq_datain_tag, pixel_datain_tag, datain};
        if (!rst) begin
            if (start && start_cyc < 0) start_cyc = cyc;
            if (new_map) begin new_map_cnt++; new_map_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (datain_valid) begin
                n_vec++;
                if (seq_datain_tag && pixel_datain_tag) begin
                    n_err++; $display("FAIL both_tags: seq=%b pix=%b at cycle %0d", seq_datain_tag, pixel_datain_tag, cyc);
                end
            end
            if (prev_stall) begin
                stall_cycles++;
                n_vec++;
                if (obs !== prev_obs || datain_valid !== 1'b1) begin
                    n_err++; $display("FAIL stall_hold: got %h valid %b, held word was %h", obs, datain_valid, prev_obs);
                end
            end
            if (x) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL unexpected_xfer: got %h, scoreboard empty", obs);
                end else begin
                    exp_w = sb.pop_front();
                    if (obs !== exp_w) begin
                        n_err++; $display("FAIL xfer_word: got %h want %h", obs, exp_w);
                    end
                end
                if (seq_datain_tag) begin
                    seq_xfers++;
                    if (first_seq_cyc < 0) first_seq_cyc = cyc;
                    last_seq_cyc = cyc;
                end else begin
                    pix_xfers++;
                    if (first_pix_cyc < 0) first_pix_cyc = cyc;
                    last_pix_cyc = cyc;
                end
            end
        end
        prev_stall = !rst && datain_valid && !x;
        prev_obs   = obs;
    end

    task automatic clear_stats();
        seq_xfers = 0; pix_xfers = 0; first_seq_cyc = -1; last_seq_cyc = -1;
        first_pix_cyc = -1; last_pix_cyc = -1; done_cnt = 0; done_cyc = -1;
        new_map_cnt = 0; new_map_cyc = -1; start_cyc = -1; stall_cycles = 0;
    endtask

    task automatic push_words(input int n, input bit is_seq);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = DW'($urandom);
            fifo.push_back(d);
            sb.push_back({is_seq, !is_seq, d});
        end
    endtask

    task automatic pulse_start(input int n, input int lc, input int lr);
        @(negedge clk); #1;
        cfg_num_seq_words = SW'(n);
        cfg_last_col      = CW'(lc);
        cfg_last_row      = CW'(lr);
        start             = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_low);
        int k;
        k = 0;
        busy_low = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk); #3;
            if (busy !== 1'b1) busy_low++;
            k++;
        end
        n_vec++;
        if (done_cnt == 0) begin
            n_err++; $display("FAIL wait_done: done not seen, waited %0d of %0d cycles", k, budget);
        end
        @(negedge clk); #3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #2;
        n_vec++;
        if ({src_rden, new_map, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                {src_rden, new_map, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done});
        end
        n_vec++;
        if (datain !== '0) begin n_err++; $display("FAIL reset_datain: got %h want 0", datain); end
    endtask

    task automatic test_basic();
        int bl;
        clear_stats();
        push_words(4, 1'b1);
        push_words(12, 1'b0);
        pulse_start(4, 3, 2);
        wait_done(200, bl);
        n_vec++; if (new_map_cyc !== start_cyc + 1) begin n_err++; $display("FAIL basic_new_map_lat: got cycle %0d want %0d", new_map_cyc, start_cyc + 1); end
        n_vec++; if (new_map_cnt !== 1) begin n_err++; $display("FAIL basic_new_map_cnt: got %0d want 1", new_map_cnt); end
        n_vec++; if (seq_xfers !== 4) begin n_err++; $display("FAIL basic_seq_cnt: got %0d want 4", seq_xfers); end
        n_vec++; if (last_seq_cyc - first_seq_cyc !== 3) begin n_err++; $display("FAIL basic_seq_span: got %0d want 3", last_seq_cyc - first_seq_cyc); end
        n_vec++; if (pix_xfers !== 12) begin n_err++; $display("FAIL basic_pix_cnt: got %0d want 12", pix_xfers); end
        n_vec++; if (last_pix_cyc - first_pix_cyc !== 11) begin n_err++; $display("FAIL basic_pix_span: got %0d want 11", last_pix_cyc - first_pix_cyc); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (done_cyc !== last_pix_cyc + 1) begin n_err++; $display("FAIL basic_done_lat: got %0d want %0d", done_cyc, last_pix_cyc + 1); end
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL basic_sb_left: got %0d want 0", sb.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        n_vec++; if (bl !== 0) begin n_err++; $display("FAIL basic_busy_low: got %0d want 0", bl); end
    endtask

    task automatic test_row_stall();
        int bl;
        int last;
        int k;
        clear_stats();
        last = 0;
        k = 0;
        push_words(4, 1'b1);
        push_words(12, 1'b0);
        pulse_start(4, 3, 2);
        while (pix_xfers < 12 && k < 1000) begin
            @(negedge clk); #1;
            k++;
            if (pix_xfers > 0 && pix_xfers % 4 == 0 && pix_xfers < 12 && pix_xfers != last) begin
                last = pix_xfers;
                pixel_datain_rdy = 1'b0;
                repeat (20) @(negedge clk);
                #1 pixel_datain_rdy = 1'b1;
            end
        end
        wait_done(100, bl);
        n_vec++; if (pix_xfers !== 12) begin n_err++; $display("FAIL stall_pix_cnt: got %0d want 12", pix_xfers); end
        n_vec++; if (seq_xfers !== 4) begin n_err++; $display("FAIL stall_seq_cnt: got %0d want 4", seq_xfers); end
        n_vec++; if (stall_cycles < 40) begin n_err++; $display("FAIL stall_cycles: got %0d want >=40", stall_cycles); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL stall_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_fifo_starve();
        int bl;
        int k;
        clear_stats();
        k = 0;
        push_words(2, 1'b1);
        pulse_start(4, 3, 2);
        while (seq_xfers < 2 && k < 100) begin @(negedge clk); #3; k++; end
        repeat (5) begin
            @(negedge clk); #3;
            n_vec++;
            if ({datain_valid, pixel_datain_tag} !== 2'b00) begin
                n_err++; $display("FAIL starve_idle: got valid=%b pix_tag=%b want 0 0", datain_valid, pixel_datain_tag);
            end
        end
        @(negedge clk); #1;
        push_words(2, 1'b1);
        push_words(12, 1'b0);
        wait_done(200, bl);
        n_vec++; if (seq_xfers !== 4) begin n_err++; $display("FAIL starve_seq_cnt: got %0d want 4", seq_xfers); end
        n_vec++; if (pix_xfers !== 12) begin n_err++; $display("FAIL starve_pix_cnt: got %0d want 12", pix_xfers); end
        n_vec++; if (last_seq_cyc - first_seq_cyc < 8) begin n_err++; $display("FAIL starve_gap: got span %0d want >=8", last_seq_cyc - first_seq_cyc); end
        n_vec++; if (first_pix_cyc <= last_seq_cyc) begin n_err++; $display("FAIL starve_tag_order: first pix %0d last seq %0d", first_pix_cyc, last_seq_cyc); end
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL starve_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_start_ignored();
        int bl;
        int k;
        clear_stats();
        k = 0;
        push_words(4, 1'b1);
        push_words(12, 1'b0);
        pulse_start(4, 3, 2);
        while (pix_xfers < 3 && k < 100) begin @(negedge clk); #3; k++; end
        pulse_start(1, 0, 0);
        wait_done(200, bl);
        repeat (5) @(negedge clk);
        #3;
        n_vec++; if (new_map_cnt !== 1) begin n_err++; $display("FAIL restart_new_map_cnt: got %0d want 1", new_map_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (pix_xfers !== 12) begin n_err++; $display("FAIL restart_pix_cnt: got %0d want 12", pix_xfers); end
        n_vec++; if (bl !== 0) begin n_err++; $display("FAIL restart_busy_low: got %0d want 0", bl); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_busy_after: got %b want 0", busy); end
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL restart_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_pix();
        int bl;
        int k;
        clear_stats();
        k = 0;
        push_words(4, 1'b1);
        push_words(12, 1'b0);
        pulse_start(4, 3, 2);
        while (pix_xfers < 5 && k < 100) begin @(negedge clk); #3; k++; end
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        fifo.delete();
        sb.delete();
        #2;
        n_vec++;
        if ({src_rden, new_map, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done} !== 7'b0) begin
            n_err++; $display("FAIL midrst_ctrl: got %b want 0000000",
                {src_rden, new_map, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done});
        end
        n_vec++; if (datain !== '0) begin n_err++; $display("FAIL midrst_datain: got %h want 0", datain); end
        clear_stats();
        push_words(2, 1'b1);
        push_words(4, 1'b0);
        pulse_start(2, 1, 1);
        wait_done(200, bl);
        n_vec++; if (seq_xfers !== 2) begin n_err++; $display("FAIL midrst_seq_cnt: got %0d want 2", seq_xfers); end
        n_vec++; if (pix_xfers !== 4) begin n_err++; $display("FAIL midrst_pix_cnt: got %0d want 4", pix_xfers); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL midrst_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL midrst_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_min_map();
        int bl;
        clear_stats();
        push_words(1, 1'b1);
        push_words(1, 1'b0);
        pulse_start(1, 0, 0);
        wait_done(100, bl);
        n_vec++; if (seq_xfers !== 1) begin n_err++; $display("FAIL min_seq_cnt: got %0d want 1", seq_xfers); end
        n_vec++; if (pix_xfers !== 1) begin n_err++; $display("FAIL min_pix_cnt: got %0d want 1", pix_xfers); end
        n_vec++; if (first_pix_cyc <= last_seq_cyc) begin n_err++; $display("FAIL min_order: pix %0d seq %0d", first_pix_cyc, last_seq_cyc); end
        n_vec++; if (done_cyc !== last_pix_cyc + 1) begin n_err++; $display("FAIL min_done_lat: got %0d want %0d", done_cyc, last_pix_cyc + 1); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL min_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL min_sb_left: got %0d want 0", sb.size()); end
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        cfg_num_seq_words = '0;
        cfg_last_col      = '0;
        cfg_last_row      = '0;
        seq_datain_rdy    = 1'b1;
        pixel_datain_rdy  = 1'b1;
        clear_stats();
        test_reset();
        test_basic();
        test_row_stall();
        test_fifo_starve();
        test_start_ignored();
        test_reset_mid_pix();
        test_min_map();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
